// File: rtl/plot_capture_pkg.sv
// Shared types, frame-store geometry and address helpers for the pixel-plot capture block.
package plot_capture_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int CNT_W    = 16;
  localparam int FB_DEPTH = SCREEN_W * SCREEN_H;
  localparam int ADDR_W   = 15;

  typedef enum logic {
    CAP_CLEAR  = 1'b0,
    CAP_ACTIVE = 1'b1
  } cap_state_t;

  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  endfunction

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return ADDR_W'(int'(y) * SCREEN_W + int'(x));
  endfunction

endpackage

// File: rtl/plot_capture_if.sv
// Pixel-plot bus from the drawing engine: one pixel per cycle while vga_plot is high.
interface plot_capture_if;
  import plot_capture_pkg::*;

  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (output vga_x, vga_y, vga_colour, vga_plot);
  modport slave  (input  vga_x, vga_y, vga_colour, vga_plot);
endinterface

// File: rtl/plot_capture_ram.sv
// Frame store: single clock, one write and one registered read port, read-before-write.
module plot_capture_ram
  import plot_capture_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int WIDTH = COLOUR_W,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both ports in one block so a same-address read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/plot_capture.sv
// Shadows plotted pixels into a 160x120x3 frame store with plot/out-of-range counters and readback.
// Optional first-out-of-range coordinate log enabled by defining PLOT_CAPTURE_OOB_LOG_EN.
//
// state      | meaning
// CAP_CLEAR  | sweeping zeros through the frame store, plots ignored, busy high
// CAP_ACTIVE | accepting plots, counting, readback returns stored colour
module plot_capture
  import plot_capture_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  plot_capture_if.slave       pix,
  input  logic                clear_req,
  output logic                busy,
  output logic                clear_done,
  input  logic                rd_en,
  input  logic [7:0]          rd_x,
  input  logic [6:0]          rd_y,
  output logic                rd_valid,
  output logic [COLOUR_W-1:0] rd_colour,
  output logic [CNT_W-1:0]    plot_count,
`ifdef PLOT_CAPTURE_OOB_LOG_EN
  output logic                first_oob_valid,
  output logic [7:0]          first_oob_x,
  output logic [6:0]          first_oob_y,
`endif
  output logic [CNT_W-1:0]    oob_count
);

  cap_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   sweep_addr;
  logic                sweep_last;
  logic                plot_in;
  logic [ADDR_W-1:0]   plot_addr;
  logic                rd_in;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_zero_q;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [COLOUR_W-1:0] ram_wdata;
  logic [COLOUR_W-1:0] ram_q;

  assign sweep_last = (sweep_addr == ADDR_W'(FB_DEPTH - 1));
  assign plot_in    = on_screen(pix.vga_x, pix.vga_y);
  assign plot_addr  = plot_in ? fb_addr(pix.vga_x, pix.vga_y) : '0;
  assign rd_in      = on_screen(rd_x, rd_y);
  assign rd_addr    = rd_in ? fb_addr(rd_x, rd_y) : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= CAP_CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    clear_done = 1'b0;
    case (state_q)
      CAP_CLEAR: begin
        busy = 1'b1;
        if (sweep_last) begin
          clear_done = 1'b1;
          state_d    = CAP_ACTIVE;
        end
      end
      CAP_ACTIVE: begin
        if (clear_req) state_d = CAP_CLEAR;
      end
      default: state_d = CAP_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state_q != CAP_CLEAR || sweep_last) sweep_addr <= '0;
    else                                           sweep_addr <= sweep_addr + 1'b1;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = plot_addr;
    ram_wdata = pix.vga_colour;
    if (state_q == CAP_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_addr;
      ram_wdata = '0;
    end else if (pix.vga_plot && plot_in) begin
      ram_we = 1'b1;
    end
  end

  plot_capture_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .q     (ram_q)
  );

  // The RAM output is never reset, so off-screen and mid-sweep reads are masked here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_zero_q <= !rd_in || (state_q == CAP_CLEAR);
    end
  end

  assign rd_colour = rd_zero_q ? '0 : ram_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == CAP_CLEAR || clear_req) begin
      plot_count <= '0;
      oob_count  <= '0;
    end else if (pix.vga_plot) begin
      if (plot_in) begin
        if (plot_count != '1) plot_count <= plot_count + 1'b1;
      end else begin
        if (oob_count != '1) oob_count <= oob_count + 1'b1;
      end
    end
  end

`ifdef PLOT_CAPTURE_OOB_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || state_q == CAP_CLEAR || clear_req) begin
      first_oob_valid <= 1'b0;
      first_oob_x     <= '0;
      first_oob_y     <= '0;
    end else if (pix.vga_plot && !plot_in && !first_oob_valid) begin
      first_oob_valid <= 1'b1;
      first_oob_x     <= pix.vga_x;
      first_oob_y     <= pix.vga_y;
    end
  end
`endif

endmodule

// File: tb/tb_plot_capture.sv
// Directed bench for plot_capture: clear sweep, plotting, counters, readback ordering, clear_req.
module tb_plot_capture;
  import plot_capture_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                clear_req;
  logic                busy;
  logic                clear_done;
  logic                rd_en;
  logic [7:0]          rd_x;
  logic [6:0]          rd_y;
  logic                rd_valid;
  logic [COLOUR_W-1:0] rd_colour;
  logic [CNT_W-1:0]    plot_count;
  logic [CNT_W-1:0]    oob_count;
`ifdef PLOT_CAPTURE_OOB_LOG_EN
  logic                first_oob_valid;
  logic [7:0]          first_oob_x;
  logic [6:0]          first_oob_y;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  plot_capture_if pix ();

  plot_capture dut (
    .clk        (clk),
    .rst        (rst),
    .pix        (pix),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .rd_colour  (rd_colour),
    .plot_count (plot_count),
`ifdef PLOT_CAPTURE_OOB_LOG_EN
    .first_oob_valid (first_oob_valid),
    .first_oob_x     (first_oob_x),
    .first_oob_y     (first_oob_y),
`endif
    .oob_count  (oob_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    pix.vga_x      = 8'(x);
    pix.vga_y      = 7'(y);
    pix.vga_colour = COLOUR_W'(c);
    pix.vga_plot   = 1'b1;
    tick();
    pix.vga_plot   = 1'b0;
  endtask

  task automatic read(input string tag, input int x, input int y, input int exp);
    rd_en = 1'b1;
    rd_x  = 8'(x);
    rd_y  = 7'(y);
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, int'(rd_valid), 1);
    check(tag, int'(rd_colour), exp);
  endtask

  // Runs until busy drops; returns busy-cycle count and the 1-based cycle of clear_done.
  task automatic wait_sweep(output int cycles, output int done_at);
    int budget;
    cycles  = 0;
    done_at = 0;
    budget  = 25000;
    while (busy && budget > 0) begin
      cycles++;
      if (clear_done) done_at = cycles;
      tick();
      budget--;
    end
    if (budget == 0) check("sweep_timeout", 1, 0);
  endtask

  initial begin
    int cycles, done_at;
    rst            = 1'b1;
    clear_req      = 1'b0;
    rd_en          = 1'b0;
    rd_x           = '0;
    rd_y           = '0;
    pix.vga_x      = '0;
    pix.vga_y      = '0;
    pix.vga_colour = '0;
    pix.vga_plot   = 1'b0;
    tick();
    check("rst_busy", int'(busy), 1);
    check("rst_done", int'(clear_done), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_colour", int'(rd_colour), 0);
    check("rst_plot_count", int'(plot_count), 0);
    check("rst_oob_count", int'(oob_count), 0);
    rst = 1'b0;

    wait_sweep(cycles, done_at);
    check("sweep_cycles", cycles, 19200);
    check("sweep_done_at", done_at, 19200);
    check("sweep_busy_after", int'(busy), 0);
    check("sweep_done_after", int'(clear_done), 0);

    plot(10, 20, 5);
    read("rd_10_20", 10, 20, 5);
    check("plot_count_1", int'(plot_count), 1);
    tick();
    check("rd_valid_drop", int'(rd_valid), 0);

    plot(160, 5, 7);
    plot(3, 120, 7);
    check("oob_count_2", int'(oob_count), 2);
    check("plot_count_still_1", int'(plot_count), 1);
    read("rd_3_119", 3, 119, 0);
    read("rd_offscreen", 200, 0, 0);

    plot(7, 7, 1);
    pix.vga_x      = 8'd7;
    pix.vga_y      = 7'd7;
    pix.vga_colour = 3'd3;
    pix.vga_plot   = 1'b1;
    read("rd_rbw_old", 7, 7, 1);
    pix.vga_plot   = 1'b0;
    read("rd_rbw_new", 7, 7, 3);
    check("plot_count_3", int'(plot_count), 3);

    plot(159, 119, 7);
    read("rd_corner", 159, 119, 7);
    plot(10, 20, 0);
    read("rd_colour0", 10, 20, 0);
    check("plot_count_5", int'(plot_count), 5);

    pix.vga_x      = 8'd0;
    pix.vga_y      = 7'd0;
    pix.vga_colour = 3'd6;
    pix.vga_plot   = 1'b1;
    clear_req      = 1'b1;
    tick();
    clear_req      = 1'b0;
    pix.vga_plot   = 1'b0;
    check("clr_busy", int'(busy), 1);
    check("clr_plot_count", int'(plot_count), 0);
    check("clr_oob_count", int'(oob_count), 0);
    plot(1, 1, 2);
    plot(2, 2, 2);
    check("clr_plots_ignored", int'(plot_count), 0);
    read("rd_during_clear", 159, 119, 0);
    wait_sweep(cycles, done_at);
    check("clr_done_seen", int'(done_at != 0), 1);
    check("clr_busy_after", int'(busy), 0);
    check("clr_plot_count_after", int'(plot_count), 0);
    read("rd_0_0_cleared", 0, 0, 0);
    read("rd_corner_cleared", 159, 119, 0);
    read("rd_1_1_cleared", 1, 1, 0);

`ifdef PLOT_CAPTURE_OOB_LOG_EN
    check("log_valid_clear", int'(first_oob_valid), 0);
    plot(200, 10, 1);
    plot(170, 3, 1);
    check("log_valid", int'(first_oob_valid), 1);
    check("log_x", int'(first_oob_x), 200);
    check("log_y", int'(first_oob_y), 10);
    check("log_oob_count", int'(oob_count), 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
